melay_seq_0100: RTL and testbench
=================================

# melay_seq_0100

Mealy-style serial bit-sequence detector that flags each occurrence of the pattern 0-1-0-0 on a one-bit input stream. One input bit is consumed per rising clock edge. The detect output is combinational from current state and current input. It is a leaf control block feeding downstream pattern/event logic.

## Interface
- `OVERLAP`, default 1: 1 means overlapping matches are detected, so a match's trailing 0 may start the next match. 0 means the detector restarts from idle after every match.
- `clk`, input, 1: single clock. All state updates happen on the rising edge.
- `rst`, input, 1: reset is synchronous and active-high.
- `x`, input, 1: serial data bit, sampled on each rising `clk` edge.
- `out`, output, 1: detect flag, asserted when the already-consumed bits are 0-1-0 and the current `x` = 0.

## Operation
- States, encoded as 2-bit constants:
  - `S_IDLE`: no useful prefix.
  - `S_0`: "0" seen.
  - `S_01`: "01" seen.
  - `S_010`: "010" seen.
- Transitions, listed as current state, x → next state, out:
  - `S_IDLE`: 0 → `S_0`, out 0. 1 → `S_IDLE`, out 0.
  - `S_0`: 0 → `S_0`, out 0. 1 → `S_01`, out 0.
  - `S_01`: 0 → `S_010`, out 0. 1 → `S_IDLE`, out 0.
  - `S_010`, x=0: out 1. Next state is `S_0` if `OVERLAP`=1, else `S_IDLE`.
  - `S_010`, x=1: → `S_01`, out 0. The suffix "01" is a valid prefix.
- `out` = (state == `S_010`) && (x == 0) && !rst. It is purely combinational, with no output register.
- Unused state encodings are never reached. Defensively, a default branch forces the next state to `S_IDLE` with out 0.
- If `x` is X/Z, the next state is `S_IDLE` and out is 0.

## Timing
- Reset:
  - `rst` high at a rising edge sets the state to `S_IDLE`.
  - `out` is 0 for as long as `rst` is high, regardless of state or `x`.
- Latency: `out` rises combinationally within the same cycle that the final 0 is present on `x`. It is valid before the rising edge that consumes that bit, and it drops after that edge when the state leaves `S_010`.
- Drive `x` away from the rising edge, for example on the falling edge. `out` may then be high for less than a full clock period, and consumers must sample it on the rising edge.
- Reset mid-sequence discards any partial match. The first bit after reset release starts from `S_IDLE`.
- A long run of zeros holds `S_0` indefinitely and produces no false match.
- With `OVERLAP`=1, "0100100" yields two detects, on bit 4 and bit 7.
- With `OVERLAP`=0, "0100100" yields one detect, on bit 4 only.

## Structure
- Shared package `melay_seq_pkg` holds the state enum/localparams (`S_IDLE`=2'd0, `S_0`=2'd1, `S_01`=2'd2, `S_010`=2'd3) and the pattern constant 4'b0100.
- Single module with no sub-modules:
  - one registered state process;
  - one combinational next-state/output process;
  - optional assertion block (state always legal; `out` implies state == `S_010`).

## Test plan
- Reset: hold `rst`=1 for 2 cycles with x toggling → `out` stays 0 throughout and the state is `S_IDLE` after release.
- Basic plus overlap, `OVERLAP`=1: after reset, feed 0,1,0,0,1,0,0,0,1 → `out`=1 only while bit 4 and bit 7 are applied. Final state is `S_01`.
- Non-overlap, `OVERLAP`=0: the same stream → `out`=1 only on bit 4.
- Partial-match recovery: feed 0,1,0,1,0,0 → `out`=1 only on bit 6, via the `S_010`,x=1 → `S_01` path.
- Negative cases:
  - feed 0,1,1,0,0 → `out` never 1;
  - feed 1,1,1,1 → `out` never 1, state stays `S_IDLE`.
- Reset mid-match: feed 0,1,0, assert `rst` for one cycle, then 0 → `out` stays 0, and a subsequent 1,0,0 still does not fire until a full 0,1,0,0 is seen.

Source files
------------

// File: rtl/melay_seq_0100_pkg.sv
// Shared types for the 0-1-0-0 serial sequence detector.
// State encoding and the pattern being matched.
package melay_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_0    = 2'd1,
        S_01   = 2'd2,
        S_010  = 2'd3
    } state_e;

    localparam logic [3:0] PATTERN = 4'b0100;

endpackage

// File: rtl/melay_seq_0100.sv
// Mealy detector for 0-1-0-0 on a serial bit stream.
// out is combinational from the current state and the current x.
module melay_seq_0100
    import melay_seq_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic out
);

    state_e state_q;
    state_e state_d;
    logic   hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Unknown x or an illegal state falls through to the default.
    always_comb begin
        state_d = S_IDLE;
        case ({state_q, x})
            {S_IDLE, 1'b0}: state_d = S_0;
            {S_IDLE, 1'b1}: state_d = S_IDLE;
            {S_0,    1'b0}: state_d = S_0;
            {S_0,    1'b1}: state_d = S_01;
            {S_01,   1'b0}: state_d = S_010;
            {S_01,   1'b1}: state_d = S_IDLE;
            {S_010,  1'b0}: state_d = OVERLAP ? S_0 : S_IDLE;
            {S_010,  1'b1}: state_d = S_01;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hit = 1'b0;
        case ({state_q, x})
            {S_010, 1'b0}: hit = 1'b1;
            default:       hit = 1'b0;
        endcase
        out = hit & ~rst;
    end

    a_out_in_010: assert property (
        @(posedge clk) disable iff (rst) out |-> (state_q == S_010)
    );

endmodule

// File: tb/tb_melay_seq_0100.sv
// Randomised and directed bench for melay_seq_0100, both OVERLAP settings.
// Reference model keeps the recent bit history and looks for 0-1-0 + x=0.
module tb_melay_seq_0100;
    import melay_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic x;
    logic out_ov;
    logic out_no;

    bit exp_ov;
    bit exp_no;
    bit q_ov[$];
    bit q_no[$];
    int n_checks = 0;
    int n_fail = 0;

    melay_seq_0100 #(.OVERLAP(1'b1)) dut_ov (
        .clk(clk), .rst(rst), .x(x), .out(out_ov)
    );

    melay_seq_0100 #(.OVERLAP(1'b0)) dut_no (
        .clk(clk), .rst(rst), .x(x), .out(out_no)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic bit tail_010(input bit q[$]);
        if (q.size() < 3) return 1'b0;
        return q[q.size()-3] == 1'b0 && q[q.size()-2] == 1'b1
            && q[q.size()-1] == 1'b0;
    endfunction

    // Apply inputs mid-cycle and compute the expected detect flags.
    task automatic drive(input bit b, input bit r);
        @(negedge clk);
        x = b;
        rst = r;
        #1;
        exp_ov = !r && (b == 1'b0) && tail_010(q_ov);
        exp_no = !r && (b == 1'b0) && tail_010(q_no);
    endtask

    // Consume the bit on the rising edge, advancing the reference model.
    task automatic commit();
        @(posedge clk);
        if (rst) begin
            q_ov.delete();
            q_no.delete();
        end else begin
            q_ov.push_back(x);
            q_no.push_back(x);
            if (exp_no) q_no.delete();
            while (q_ov.size() > 3) void'(q_ov.pop_front());
            while (q_no.size() > 3) void'(q_no.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(i[0], 1'b1);
            n_checks += 2;
            if (out_ov !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_out_ov cyc %0d: got %b want 0", i, out_ov);
            end
            if (out_no !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_out_no cyc %0d: got %b want 0", i, out_no);
            end
            commit();
        end
        n_checks++;
        if (dut_ov.state_q !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", dut_ov.state_q, S_IDLE);
        end
    endtask

    task automatic test_basic_overlap();
        bit seq[9];
        int hits_ov = 0;
        int hits_no = 0;
        seq = '{0, 1, 0, 0, 1, 0, 0, 0, 1};
        drive(1'b0, 1'b1);
        commit();
        foreach (seq[i]) begin
            drive(seq[i], 1'b0);
            n_checks += 2;
            if (out_ov !== exp_ov) begin
                n_fail++;
                $display("FAIL basic_ov bit %0d: got %b want %b", i + 1, out_ov, exp_ov);
            end
            if (out_no !== exp_no) begin
                n_fail++;
                $display("FAIL basic_no bit %0d: got %b want %b", i + 1, out_no, exp_no);
            end
            if (out_ov === 1'b1 && i != 3 && i != 6) begin
                n_fail++;
                $display("FAIL basic_ov_pos bit %0d: got 1 want 0", i + 1);
            end
            hits_ov += int'(out_ov === 1'b1);
            hits_no += int'(out_no === 1'b1);
            commit();
        end
        n_checks += 4;
        if (hits_ov != 2) begin
            n_fail++;
            $display("FAIL basic_ov_count: got %0d want 2", hits_ov);
        end
        if (hits_no != 1) begin
            n_fail++;
            $display("FAIL basic_no_count: got %0d want 1", hits_no);
        end
        if (dut_ov.state_q !== S_01) begin
            n_fail++;
            $display("FAIL basic_final_state: got %0d want %0d", dut_ov.state_q, S_01);
        end
        if (out_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_out_drop: got %b want 0", out_ov);
        end
    endtask

    task automatic test_partial_recovery();
        bit seq[6];
        int hits = 0;
        seq = '{0, 1, 0, 1, 0, 0};
        drive(1'b0, 1'b1);
        commit();
        foreach (seq[i]) begin
            drive(seq[i], 1'b0);
            n_checks += 2;
            if (out_ov !== exp_ov) begin
                n_fail++;
                $display("FAIL partial_ov bit %0d: got %b want %b", i + 1, out_ov, exp_ov);
            end
            if (out_no !== exp_no) begin
                n_fail++;
                $display("FAIL partial_no bit %0d: got %b want %b", i + 1, out_no, exp_no);
            end
            if (i == 5) hits += int'(out_ov === 1'b1);
            commit();
        end
        n_checks++;
        if (hits != 1) begin
            n_fail++;
            $display("FAIL partial_bit6: got %0d detects want 1", hits);
        end
    endtask

    task automatic test_negative();
        bit seq[9];
        int hits = 0;
        seq = '{0, 1, 1, 0, 0, 1, 1, 1, 1};
        drive(1'b0, 1'b1);
        commit();
        foreach (seq[i]) begin
            drive(seq[i], 1'b0);
            hits += int'(out_ov === 1'b1) + int'(out_no === 1'b1);
            commit();
        end
        n_checks += 2;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL negative_hits: got %0d want 0", hits);
        end
        if (dut_ov.state_q !== S_IDLE) begin
            n_fail++;
            $display("FAIL negative_state: got %0d want %0d", dut_ov.state_q, S_IDLE);
        end
    endtask

    task automatic test_reset_mid_match();
        bit seq[11];
        bit rs[11];
        int early = 0;
        int late = 0;
        seq = '{0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0};
        rs  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        drive(1'b0, 1'b1);
        commit();
        foreach (seq[i]) begin
            drive(seq[i], rs[i]);
            n_checks += 2;
            if (out_ov !== exp_ov) begin
                n_fail++;
                $display("FAIL rst_mid_ov bit %0d: got %b want %b", i + 1, out_ov, exp_ov);
            end
            if (out_no !== exp_no) begin
                n_fail++;
                $display("FAIL rst_mid_no bit %0d: got %b want %b", i + 1, out_no, exp_no);
            end
            if (i < 7) early += int'(out_ov === 1'b1);
            else late += int'(out_ov === 1'b1);
            commit();
        end
        n_checks += 2;
        if (early != 0) begin
            n_fail++;
            $display("FAIL rst_mid_early: got %0d detects want 0", early);
        end
        if (late != 1) begin
            n_fail++;
            $display("FAIL rst_mid_late: got %0d detects want 1", late);
        end
    endtask

    task automatic test_long_zeros();
        int hits = 0;
        drive(1'b0, 1'b1);
        commit();
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b0);
            hits += int'(out_ov === 1'b1) + int'(out_no === 1'b1);
            commit();
        end
        n_checks += 2;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL long_zeros_hits: got %0d want 0", hits);
        end
        if (dut_ov.state_q !== S_0) begin
            n_fail++;
            $display("FAIL long_zeros_state: got %0d want %0d", dut_ov.state_q, S_0);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
            n_checks += 2;
            if (out_ov !== exp_ov) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_ov step %0d: got %b want %b", i, out_ov, exp_ov);
            end
            if (out_no !== exp_no) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_no step %0d: got %b want %b", i, out_no, exp_no);
            end
            commit();
        end
    endtask

    initial begin
        rst = 1'b1;
        x = 1'b0;
        test_reset();
        test_basic_overlap();
        test_partial_recovery();
        test_negative();
        test_reset_mid_match();
        test_long_zeros();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
